run_event_counter: RTL and testbench

//  Downstream consumer of the 4-in-a-row sequence detector FSM (part2).
//  - Watches the detector output z and its state code y.
//  - Counts completed runs of four 0s (entry into state E) and four 1s (entry into state I).
//  - Drives four active-low 7-segment digits with both counts.
//  - Shares the detector's clock (KEY[0]) and resetn (SW[0]).

---
 rtl/run_event_counter_pkg.sv | 27 ++
 rtl/run_event_counter_hex7seg.sv | 31 +++
 rtl/run_event_counter.sv | 116 +++++++++++
 tb/tb_run_event_counter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/run_event_counter_pkg.sv
// Shared definitions for the run event counter: detector state codes,
// default counter width and the run-kind encoding.
package run_event_counter_pkg;

   // Default counter width; the display always shows the low 8 bits.
   localparam int CNT_W = 8;

   // Present-state codes of the 4-in-a-row sequence detector.
   typedef enum logic [3:0] {
      DET_A = 4'b0000,
      DET_B = 4'b0001,
      DET_C = 4'b0010,
      DET_D = 4'b0011,
      DET_E = 4'b0100,
      DET_F = 4'b0101,
      DET_G = 4'b0110,
      DET_H = 4'b0111,
      DET_I = 4'b1000
   } det_state_e;

   // Kind of the most recently counted run.
   typedef enum logic {
      KIND_ZEROS = 1'b0,
      KIND_ONES  = 1'b1
   } run_kind_e;

endpackage

// File: rtl/run_event_counter_hex7seg.sv
// Hex digit to active-low 7-segment decoder; segment order [6:0] = g..a.
module run_event_counter_hex7seg (
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   // Pure lookup from nibble to lit segments (0 = lit).
   always_comb begin
      o_seg = 7'b1111111;
      case (i_digit)
         4'h0: o_seg = 7'b1000000;
         4'h1: o_seg = 7'b1111001;
         4'h2: o_seg = 7'b0100100;
         4'h3: o_seg = 7'b0110000;
         4'h4: o_seg = 7'b0011001;
         4'h5: o_seg = 7'b0010010;
         4'h6: o_seg = 7'b0000010;
         4'h7: o_seg = 7'b1111000;
         4'h8: o_seg = 7'b0000000;
         4'h9: o_seg = 7'b0010000;
         4'hA: o_seg = 7'b0001000;
         4'hB: o_seg = 7'b0000011;
         4'hC: o_seg = 7'b1000110;
         4'hD: o_seg = 7'b0100001;
         4'hE: o_seg = 7'b0000110;
         4'hF: o_seg = 7'b0001110;
         default: o_seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/run_event_counter.sv
// Counts completed runs of four 0s / four 1s reported by the sequence
// detector. A run is counted once, on the edge after z rises, using the
// detector state code present at that edge to decide which kind it was.
// Valid/ready: there is no handshake; every rising edge of z is an event
// that is either counted, flagged as a coding error, or dropped by clear.
module run_event_counter
   import run_event_counter_pkg::*;
#(
   parameter int         W       = CNT_W,
   parameter logic [3:0] STATE_E = DET_E,
   parameter logic [3:0] STATE_I = DET_I
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         clear,
   input  logic         z,
   input  logic [3:0]   state,
   output logic [W-1:0] zero_runs,
   output logic [W-1:0] one_runs,
   output logic         zero_sat,
   output logic         one_sat,
   output logic         last_kind,
   output logic         last_valid,
   output logic         code_err,
   output logic [6:0]   HEX0,
   output logic [6:0]   HEX1,
   output logic [6:0]   HEX2,
   output logic [6:0]   HEX3
);

   logic         r_z_q;
   logic [W-1:0] r_zero_runs;
   logic [W-1:0] r_one_runs;
   logic         r_zero_sat;
   logic         r_one_sat;
   run_kind_e    r_last_kind;
   logic         r_last_valid;
   logic         r_code_err;

   logic         w_rise;
   logic         w_zero_max;
   logic         w_one_max;
   logic [7:0]   w_zero_disp;
   logic [7:0]   w_one_disp;

   // z held high through the E/I self-loops produces only one rise.
   assign w_rise     = z & ~r_z_q;
   assign w_zero_max = &r_zero_runs;
   assign w_one_max  = &r_one_runs;

   // Event bookkeeping: reset beats clear beats a counted rise beats hold.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_z_q        <= 1'b0;
         r_zero_runs  <= '0;
         r_one_runs   <= '0;
         r_zero_sat   <= 1'b0;
         r_one_sat    <= 1'b0;
         r_last_kind  <= KIND_ZEROS;
         r_last_valid <= 1'b0;
         r_code_err   <= 1'b0;
      end else begin
         // Edge history keeps tracking z through a clear so a held z
         // cannot re-trigger once the clear is released.
         r_z_q <= z;
         if (clear) begin
            r_zero_runs  <= '0;
            r_one_runs   <= '0;
            r_zero_sat   <= 1'b0;
            r_one_sat    <= 1'b0;
            r_last_kind  <= KIND_ZEROS;
            r_last_valid <= 1'b0;
            r_code_err   <= 1'b0;
         end else if (w_rise) begin
            if (state == STATE_E) begin
               if (w_zero_max) begin
                  r_zero_sat <= 1'b1;
               end else begin
                  r_zero_runs <= r_zero_runs + W'(1);
               end
               r_last_kind  <= KIND_ZEROS;
               r_last_valid <= 1'b1;
            end else if (state == STATE_I) begin
               if (w_one_max) begin
                  r_one_sat <= 1'b1;
               end else begin
                  r_one_runs <= r_one_runs + W'(1);
               end
               r_last_kind  <= KIND_ONES;
               r_last_valid <= 1'b1;
            end else begin
               // z can only legitimately rise on entry to E or I.
               r_code_err <= 1'b1;
            end
         end
      end
   end

   assign zero_runs  = r_zero_runs;
   assign one_runs   = r_one_runs;
   assign zero_sat   = r_zero_sat;
   assign one_sat    = r_one_sat;
   assign last_kind  = r_last_kind;
   assign last_valid = r_last_valid;
   assign code_err   = r_code_err;

   // Display taps straight off the count registers, no extra latency.
   assign w_zero_disp = r_zero_runs[7:0];
   assign w_one_disp  = r_one_runs[7:0];

   run_event_counter_hex7seg u_hex0 (.i_digit(w_zero_disp[3:0]), .o_seg(HEX0));
   run_event_counter_hex7seg u_hex1 (.i_digit(w_zero_disp[7:4]), .o_seg(HEX1));
   run_event_counter_hex7seg u_hex2 (.i_digit(w_one_disp[3:0]),  .o_seg(HEX2));
   run_event_counter_hex7seg u_hex3 (.i_digit(w_one_disp[7:4]),  .o_seg(HEX3));

endmodule

// File: tb/tb_run_event_counter.sv
// Bench for run_event_counter: a small detector stand-in turns a bit
// stream w into (state, z); a direct mode drives (state, z) by hand.
module tb_run_event_counter;

   logic       clock;
   logic       resetn;
   logic       clear;
   logic       w;
   logic       drv_direct;
   logic       direct_z;
   logic [3:0] direct_state;
   logic [3:0] det_y;
   logic       z;
   logic [3:0] state;

   logic [7:0] zero_runs;
   logic [7:0] one_runs;
   logic       zero_sat;
   logic       one_sat;
   logic       last_kind;
   logic       last_valid;
   logic       code_err;
   logic [6:0] HEX0, HEX1, HEX2, HEX3;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 0;

   // Reference model state, in plain integers.
   int m_zero, m_one;
   bit m_zsat, m_osat, m_kind, m_valid, m_err, m_prev_z;

   run_event_counter dut (
      .clock(clock), .resetn(resetn), .clear(clear), .z(z), .state(state),
      .zero_runs(zero_runs), .one_runs(one_runs),
      .zero_sat(zero_sat), .one_sat(one_sat),
      .last_kind(last_kind), .last_valid(last_valid), .code_err(code_err),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
   );

   // Clock / reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Detector stand-in: four equal bits in a row reach E (zeros) or I (ones).
   function automatic logic [3:0] det_next(input logic [3:0] y, input logic b);
      if (!b) begin
         if (y >= 4'd1 && y <= 4'd3) return 4'(y + 4'd1);
         else if (y == 4'd4)         return 4'd4;
         else                        return 4'd1;
      end else begin
         if (y >= 4'd5 && y <= 4'd7) return 4'(y + 4'd1);
         else if (y == 4'd8)         return 4'd8;
         else                        return 4'd5;
      end
   endfunction

   always @(posedge clock) begin
      if (!resetn) det_y <= 4'd0;
      else         det_y <= det_next(det_y, w);
   end

   assign state = drv_direct ? direct_state : det_y;
   assign z     = drv_direct ? direct_z : (det_y == 4'd4 || det_y == 4'd8);

   // Segment pattern for a hex digit, active low, [6:0] = g..a.
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;   1: return 7'b1111001;
         2: return 7'b0100100;   3: return 7'b0110000;
         4: return 7'b0011001;   5: return 7'b0010010;
         6: return 7'b0000010;   7: return 7'b1111000;
         8: return 7'b0000000;   9: return 7'b0010000;
         10: return 7'b0001000;  11: return 7'b0000011;
         12: return 7'b1000110;  13: return 7'b0100001;
         14: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: an event is z going from low to high between edges.
   always @(posedge clock) begin
      bit rose;
      if (!resetn) begin
         m_zero = 0; m_one = 0; m_zsat = 0; m_osat = 0;
         m_kind = 0; m_valid = 0; m_err = 0; m_prev_z = 0;
      end else begin
         rose     = z && !m_prev_z;
         m_prev_z = z;
         if (clear) begin
            m_zero = 0; m_one = 0; m_zsat = 0; m_osat = 0;
            m_kind = 0; m_valid = 0; m_err = 0;
         end else if (rose) begin
            if (state == 4'd4) begin
               if (m_zero == 255) m_zsat = 1; else m_zero = m_zero + 1;
               m_kind = 0; m_valid = 1;
            end else if (state == 4'd8) begin
               if (m_one == 255) m_osat = 1; else m_one = m_one + 1;
               m_kind = 1; m_valid = 1;
            end else begin
               m_err = 1;
            end
         end
      end
   end

   // Scoreboard compare, every cycle on the falling edge.
   always @(negedge clock) begin
      if (cmp_en) begin
         chk("zero_runs",  zero_runs,  m_zero);
         chk("one_runs",   one_runs,   m_one);
         chk("zero_sat",   zero_sat,   m_zsat);
         chk("one_sat",    one_sat,    m_osat);
         chk("last_kind",  last_kind,  m_kind);
         chk("last_valid", last_valid, m_valid);
         chk("code_err",   code_err,   m_err);
         chk("HEX0", HEX0, seg_of(m_zero % 16));
         chk("HEX1", HEX1, seg_of(m_zero / 16));
         chk("HEX2", HEX2, seg_of(m_one % 16));
         chk("HEX3", HEX3, seg_of(m_one / 16));
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic step_w(input logic b);
      drv_direct = 1'b0;
      w = b;
      tick();
   endtask

   task automatic pulse(input logic [3:0] st);
      drv_direct   = 1'b1;
      direct_state = st;
      direct_z     = 1'b1;
      tick();
      direct_z     = 1'b0;
      tick();
   endtask

   task automatic ones4();
      repeat (4) step_w(1'b1);
   endtask

   initial begin
      resetn = 1'b0; clear = 1'b0; w = 1'b0;
      drv_direct = 1'b0; direct_z = 1'b0; direct_state = 4'd0;
      tick();
      resetn = 1'b1;
      cmp_en = 1;

      // Reset state
      chk("rst zero_runs", zero_runs, 0);
      chk("rst one_runs", one_runs, 0);
      chk("rst flags", {zero_sat, one_sat, last_valid, code_err}, 0);
      chk("rst HEX0", HEX0, 7'b1000000);
      chk("rst HEX3", HEX3, 7'b1000000);

      // Four 0s: z rises after the 4th edge, count appears after the 5th
      repeat (4) step_w(1'b0);
      chk("zeros4 not yet", zero_runs, 0);
      step_w(1'b0);
      chk("zeros4 count", zero_runs, 1);
      chk("zeros4 kind", last_kind, 0);
      chk("zeros4 valid", last_valid, 1);
      repeat (8) step_w(1'b0);
      chk("zeros held", zero_runs, 1);

      // 1111 0 1111 after a clear
      clear = 1'b1; step_w(1'b1); clear = 1'b0;
      repeat (3) step_w(1'b1);
      step_w(1'b0);
      ones4();
      step_w(1'b1);
      chk("ones2 count", one_runs, 2);
      chk("ones2 zero", zero_runs, 0);
      chk("ones2 kind", last_kind, 1);
      chk("ones2 HEX3", HEX3, 7'b1000000);
      chk("ones2 HEX2", HEX2, 7'b0100100);

      // Saturation of zero_runs
      drv_direct = 1'b1; direct_z = 1'b0; direct_state = 4'd4;
      clear = 1'b1; tick(); clear = 1'b0;
      repeat (255) pulse(4'd4);
      chk("sat 255", zero_runs, 255);
      chk("sat not yet", zero_sat, 0);
      pulse(4'd4);
      chk("sat hold", zero_runs, 255);
      chk("sat flag", zero_sat, 1);
      chk("sat HEX1", HEX1, 7'b0001110);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("sat clr count", zero_runs, 0);
      chk("sat clr flag", zero_sat, 0);

      // Rise in an illegal state
      pulse(4'd3);
      chk("err flag", code_err, 1);
      chk("err zero", zero_runs, 0);
      chk("err one", one_runs, 0);

      // Clear on the same edge as a valid rise, then z held high
      direct_state = 4'd4; direct_z = 1'b1;
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clr drop", zero_runs, 0);
      chk("clr err", code_err, 0);
      tick();
      chk("clr held z", zero_runs, 0);
      direct_z = 1'b0; tick();

      // Reset while in I with one_runs = 3
      clear = 1'b1; drv_direct = 1'b0; w = 1'b0; tick(); clear = 1'b0;
      ones4(); step_w(1'b0);
      ones4(); step_w(1'b0);
      ones4(); step_w(1'b1);
      chk("pre-rst ones", one_runs, 3);
      resetn = 1'b0; step_w(1'b1); resetn = 1'b1;
      chk("mid-rst ones", one_runs, 0);
      repeat (5) step_w(1'b0);
      chk("post-rst zeros", zero_runs, 1);
      chk("post-rst ones", one_runs, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         resetn = (r < 2) ? 1'b0 : 1'b1;
         clear  = (r >= 2 && r < 6) ? 1'b1 : 1'b0;
         if ($urandom_range(0, 59) == 0) drv_direct = ~drv_direct;
         if ($urandom_range(0, 3) == 0) w = ~w;
         case ($urandom_range(0, 3))
            0: direct_state = 4'd4;
            1: direct_state = 4'd8;
            default: direct_state = 4'($urandom_range(0, 15));
         endcase
         direct_z = ($urandom_range(0, 2) == 0);
         tick();
      end
      resetn = 1'b1; clear = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
